// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results take priority over memory
// returns, which are buffered in a small FIFO; busy tracks pending loads.
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [ADR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADR_WIDTH-1:0]    mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    ld_issue,
    input  logic [ADR_WIDTH-1:0]    ld_rd,
    output logic                    we3,
    output logic [ADR_WIDTH-1:0]    a3,
    output logic [DATA_WIDTH-1:0]   wd3,
    output logic [2**ADR_WIDTH-1:0] busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADR_WIDTH-1:0]    rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    push;
    logic                    pop;
    logic [ADR_WIDTH-1:0]    head_rd;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [2**ADR_WIDTH-1:0] busy_nxt;

    assign mem_ready = (count < FULL) && !rst;
    assign push      = mem_valid && mem_ready;
    assign pop       = !alu_valid && (count != '0);
    assign head_rd   = rd_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    // A load issued to the register being retired keeps it pending.
    always_comb begin
        busy_nxt = busy;
        if (pop)
            busy_nxt[head_rd] = 1'b0;
        if (ld_issue && (ld_rd != '0))
            busy_nxt[ld_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= mem_rd;
            data_q[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
        end else begin
            busy <= busy_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Writes to x0 still retire the entry but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else begin
            unique case (1'b1)
                alu_valid: begin
                    we3 <= (alu_rd != '0);
                    a3  <= alu_rd;
                    wd3 <= alu_data;
                end
                pop: begin
                    we3 <= (head_rd != '0);
                    a3  <= head_rd;
                    wd3 <= head_data;
                end
                default: we3 <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts
// register-file writes, pending-load flags and FIFO back-pressure.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy;

    ent_t        mq[$];
    ent_t        exq[$];
    logic [31:0] bm;
    bit          acc;
    int          pass_cnt;
    int          total_cnt;

    wb_arbiter #(.DATA_WIDTH(32), .ADR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .ld_issue(ld_issue), .ld_rd(ld_rd),
        .we3(we3), .a3(a3), .wd3(wd3), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (ok)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Reference: one write source per edge, ALU first, FIFO head otherwise.
    task automatic model_update();
        ent_t e;
        acc = 1'b0;
        if (rst)
            return;
        acc = mem_valid && (mq.size() < DEPTH);
        if (alu_valid) begin
            if (alu_rd != 0)
                exq.push_back('{alu_rd, alu_data});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.rd != 0)
                exq.push_back(e);
            bm[e.rd] = 1'b0;
        end
        if (acc)
            mq.push_back('{mem_rd, mem_data});
        if (ld_issue && ld_rd != 0)
            bm[ld_rd] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic drive(input bit av, input logic [4:0] ard,
                         input logic [31:0] ad, input bit mv,
                         input logic [4:0] mrd, input logic [31:0] md,
                         input bit li, input logic [4:0] lrd);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
        ld_issue  = li;
        ld_rd     = lrd;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        mq.delete();
        exq.delete();
        bm = '0;
        #1;
        chk("rst_we3", we3 == 1'b0, 32'(we3), 0);
        chk("rst_busy", busy == '0, busy, 0);
        chk("rst_ready", mem_ready == 1'b0, 32'(mem_ready), 0);
        step();
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        ent_t e;
        chk("mem_ready", mem_ready == (!rst && mq.size() < DEPTH),
            32'(mem_ready), 32'(!rst && mq.size() < DEPTH));
        chk("busy", busy == bm, busy, bm);
        if (we3) begin
            if (exq.size() == 0) begin
                chk("spurious_write", 1'b0, 32'(a3), 0);
            end else begin
                e = exq.pop_front();
                chk("a3", a3 == e.rd, 32'(a3), 32'(e.rd));
                chk("wd3", wd3 == e.d, wd3, e.d);
            end
        end else if (exq.size() != 0) begin
            e = exq.pop_front();
            chk("missing_write", 1'b0, 32'(we3), 1);
        end
    end

    initial begin
        int mi;
        pass_cnt  = 0;
        total_cnt = 0;
        bm        = '0;
        rst       = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        idle(2);

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step();
        idle(2);

        drive(0, 0, 0, 0, 0, 0, 1, 7);
        step();
        chk("busy7_set", busy[7] == 1'b1, 32'(busy[7]), 1);
        idle(1);
        drive(0, 0, 0, 1, 7, 32'h1234, 0, 0);
        step();
        idle(1);
        chk("busy7_clr", busy[7] == 1'b0, 32'(busy[7]), 0);
        idle(2);

        mi = 0;
        for (int c = 0; c < 30 && (c < 6 || mi < 5); c++) begin
            drive(c < 6, 5'(10 + c), 32'hA0 + c,
                  mi < 5, 5'(20 + mi), 32'hB0 + mi, 0, 0);
            step();
            if (acc)
                mi++;
        end
        chk("contention_all_pushed", mi == 5, mi, 5);
        idle(6);

        drive(1, 0, 32'h1111, 1, 0, 32'h2222, 1, 0);
        step();
        idle(3);

        drive(0, 0, 0, 1, 9, 32'h9999, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        step();
        chk("busy9_collide", busy[9] == 1'b1, 32'(busy[9]), 1);
        idle(2);

        drive(1, 1, 32'h55, 1, 3, 32'h33, 1, 3);
        step();
        drive(1, 2, 32'h66, 1, 4, 32'h44, 0, 0);
        step();
        drive(1, 6, 32'h77, 1, 6, 32'h66, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        mid_reset();
        idle(6);

        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 99) < 45, 5'($urandom_range(0, 15)),
                  $urandom,
                  $urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)),
                  $urandom,
                  $urandom_range(0, 99) < 30, 5'($urandom_range(0, 15)));
            if (i == 250)
                mid_reset();
            else
                step();
        end
        idle(10);
        chk("drain", exq.size() == 0, exq.size(), 0);
        chk("fifo_empty", mq.size() == 0, mq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
